half_subtractor: RTL and testbench
==================================

Name: half_subtractor

Overview:
- Bit-parallel half subtractor: WIDTH independent lanes computing a − b per bit.
- Each lane produces a difference and a borrow-out.
- Combinational outputs are available the same cycle; a registered copy with valid qualification is available one clock later.
- A saturating counter totals borrow events for status and debug.
- Used as a leaf arithmetic primitive and as a building block for ripple subtractors.

Parameters:
- WIDTH, 1, number of independent 1-bit half-subtractor lanes (≥1).
- CNT_W, 16, width of the saturating borrow-event counter (≥1).

Ports:
- clk  input  1  single system clock; all registers sample on its rising edge.
- rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk.
- a  input  WIDTH  minuend, one bit per lane.
- b  input  WIDTH  subtrahend, one bit per lane.
- in_valid  input  1  qualifies a/b for the registered path and the counter.
- cnt_clr  input  1  synchronous clear of borrow_cnt.
- diff  output  WIDTH  combinational difference, a XOR b per lane.
- borrow  output  WIDTH  combinational borrow, (NOT a) AND b per lane.
- diff_q  output  WIDTH  registered diff.
- borrow_q  output  WIDTH  registered borrow.
- out_valid  output  1  registered in_valid.
- borrow_cnt  output  CNT_W  saturating count of accepted lanes with borrow = 1.

Behaviour:
- Combinational path, per lane i:
  - diff[i] = a[i] ^ b[i]; borrow[i] = ~a[i] & b[i].
  - No dependence on clk, rst_n or in_valid; valid during reset.
  - Truth table per lane (a, b → diff, borrow): 00→0,0; 01→1,1; 10→1,0; 11→0,0.
- Registered path:
  - On a rising clk edge with in_valid = 1: diff_q ← diff; borrow_q ← borrow.
  - On a rising clk edge with in_valid = 0: diff_q and borrow_q hold their values.
  - out_valid ← in_valid on every edge.
  - Latency is exactly 1 cycle.
- Counter:
  - On each edge with in_valid = 1, borrow_cnt increases by popcount(borrow).
  - It saturates at 2^CNT_W − 1 and never wraps.
  - The popcount adder is sized to hold WIDTH without overflow before the saturation compare.
  - If cnt_clr = 1 and in_valid = 1 in the same cycle, cnt_clr wins: borrow_cnt becomes 0 and the current borrows are discarded.
- Reset:
  - While rst_n = 0: diff_q = 0, borrow_q = 0, out_valid = 0, borrow_cnt = 0.
  - Reset takes effect immediately, asynchronously, mid-operation.
  - The first capture after release occurs on the first rising edge with rst_n = 1 and in_valid = 1.
- X-propagation: no special handling; inputs are assumed driven.

Test Plan:
- WIDTH=1, in_valid=1. Sweep {a,b} = 00, 01, 10, 11, one step per 100 ns.
  - diff = 0, 1, 1, 0; borrow = 0, 1, 0, 0.
  - diff_q/borrow_q follow one cycle later.
  - borrow_cnt ends at 1.
- Assert rst_n=0 mid-sweep, between edges → diff_q, borrow_q, out_valid and borrow_cnt drop to 0 immediately; the combinational diff/borrow still track a and b.
- WIDTH=4, a=4'b0000, b=4'b1111, in_valid=1 for 3 cycles → borrow = 4'hF, diff = 4'hF, borrow_cnt = 12.
- CNT_W=3, WIDTH=1, a=0, b=1 held with in_valid=1 for 10 cycles → borrow_cnt saturates at 7 and stays at 7.
- in_valid=0 while a/b change → diff_q/borrow_q hold, out_valid = 0, borrow_cnt unchanged.
- cnt_clr=1 together with in_valid=1 and a=0, b=1 → borrow_cnt = 0 on the next edge, not 1.

Source files
------------

// File: rtl/half_subtractor.sv
// Bit-parallel half subtractor: per-lane combinational diff/borrow, a valid-qualified
// registered copy, and a saturating counter of accepted borrow events.
module half_subtractor #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  input  logic             cnt_clr,
  output logic [WIDTH-1:0] diff,
  output logic [WIDTH-1:0] borrow,
  output logic [WIDTH-1:0] diff_q,
  output logic [WIDTH-1:0] borrow_q,
  output logic             out_valid,
  output logic [CNT_W-1:0] borrow_cnt
);

  localparam int unsigned PopW = $clog2(WIDTH + 1);
  // One spare bit above the wider operand so the sum never wraps before the saturation test.
  localparam int unsigned SumW = ((CNT_W > PopW) ? CNT_W : PopW) + 1;
  localparam logic [SumW-1:0] CntMax = {{(SumW - CNT_W){1'b0}}, {CNT_W{1'b1}}};

  logic [WIDTH-1:0] diff_d;
  logic [WIDTH-1:0] borrow_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [PopW-1:0]  pop;
  logic [SumW-1:0]  sum;

  always_comb begin
    diff   = a ^ b;
    borrow = ~a & b;
  end

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pop = pop + PopW'(borrow[i]);
    end
  end

  always_comb begin
    diff_d   = in_valid ? diff : diff_q;
    borrow_d = in_valid ? borrow : borrow_q;
    sum      = SumW'(cnt_q) + SumW'(pop);
    cnt_d    = cnt_q;
    // Clear wins over a same-cycle accept; the current borrows are dropped.
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (in_valid) begin
      cnt_d = (sum > CntMax) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q    <= '0;
      borrow_q  <= '0;
      out_valid <= 1'b0;
      cnt_q     <= '0;
    end else begin
      diff_q    <= diff_d;
      borrow_q  <= borrow_d;
      out_valid <= in_valid;
      cnt_q     <= cnt_d;
    end
  end

  assign borrow_cnt = cnt_q;

endmodule

// File: tb/tb_half_subtractor.sv
// Bench for half_subtractor: three instances (1 lane, 4 lanes, 1 lane with a 3-bit counter)
// checked every cycle against an arithmetic model, plus directed literal expectations.
module tb_half_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic cnt_clr = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic [3:0] a4 = 4'h0, b4 = 4'h0;
  logic       a_s = 1'b0, b_s = 1'b0;

  logic        d1, br1, dq1, bq1, v1;
  logic [15:0] c1;
  logic [3:0]  d4, br4, dq4, bq4;
  logic        v4;
  logic [15:0] c4;
  logic        ds, brs, dqs, bqs, vs;
  logic [2:0]  cs;

  int nchk = 0;
  int nerr = 0;

  always #50 clk = ~clk;

  half_subtractor #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .diff(d1), .borrow(br1), .diff_q(dq1), .borrow_q(bq1), .out_valid(v1), .borrow_cnt(c1)
  );

  half_subtractor #(.WIDTH(4), .CNT_W(16)) u_w4 (
    .clk(clk), .rst_n(rst_n), .a(a4), .b(b4), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .diff(d4), .borrow(br4), .diff_q(dq4), .borrow_q(bq4), .out_valid(v4), .borrow_cnt(c4)
  );

  half_subtractor #(.WIDTH(1), .CNT_W(3)) u_sat (
    .clk(clk), .rst_n(rst_n), .a(a_s), .b(b_s), .in_valid(in_valid), .cnt_clr(cnt_clr),
    .diff(ds), .borrow(brs), .diff_q(dqs), .borrow_q(bqs), .out_valid(vs), .borrow_cnt(cs)
  );

  // Model: a lane differs when its bits are unequal, borrows when a < b.
  function automatic int m_diff(input logic [3:0] a, input logic [3:0] b, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) if (int'(a[i]) - int'(b[i]) != 0) r += (1 << i);
    return r;
  endfunction

  function automatic int m_borrow(input logic [3:0] a, input logic [3:0] b, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) if (int'(a[i]) < int'(b[i])) r += (1 << i);
    return r;
  endfunction

  function automatic int m_pop(input logic [3:0] a, input logic [3:0] b, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) if (int'(a[i]) < int'(b[i])) r++;
    return r;
  endfunction

  function automatic int m_cnt(input int cnt, input int add, input int cap);
    if (cnt_clr) return 0;
    if (!in_valid) return cnt;
    return (cnt + add > cap) ? cap : cnt + add;
  endfunction

  int e1_dq, e1_bq, e1_v, e1_c;
  int e4_dq, e4_bq, e4_v, e4_c;
  int es_dq, es_bq, es_v, es_c;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e1_dq <= 0; e1_bq <= 0; e1_v <= 0; e1_c <= 0;
      e4_dq <= 0; e4_bq <= 0; e4_v <= 0; e4_c <= 0;
      es_dq <= 0; es_bq <= 0; es_v <= 0; es_c <= 0;
    end else begin
      e1_v <= int'(in_valid); e4_v <= int'(in_valid); es_v <= int'(in_valid);
      if (in_valid) begin
        e1_dq <= m_diff({3'b0, a1}, {3'b0, b1}, 1);
        e1_bq <= m_borrow({3'b0, a1}, {3'b0, b1}, 1);
        e4_dq <= m_diff(a4, b4, 4);
        e4_bq <= m_borrow(a4, b4, 4);
        es_dq <= m_diff({3'b0, a_s}, {3'b0, b_s}, 1);
        es_bq <= m_borrow({3'b0, a_s}, {3'b0, b_s}, 1);
      end
      e1_c <= m_cnt(e1_c, m_pop({3'b0, a1}, {3'b0, b1}, 1), 65535);
      e4_c <= m_cnt(e4_c, m_pop(a4, b4, 4), 65535);
      es_c <= m_cnt(es_c, m_pop({3'b0, a_s}, {3'b0, b_s}, 1), 7);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs change at posedge+10, so the falling edge sees settled inputs and model state.
  always @(negedge clk) begin
    chk("w1_diff", int'(d1), m_diff({3'b0, a1}, {3'b0, b1}, 1));
    chk("w1_borrow", int'(br1), m_borrow({3'b0, a1}, {3'b0, b1}, 1));
    chk("w1_diff_q", int'(dq1), e1_dq);
    chk("w1_borrow_q", int'(bq1), e1_bq);
    chk("w1_out_valid", int'(v1), e1_v);
    chk("w1_cnt", int'(c1), e1_c);
    chk("w4_diff", int'(d4), m_diff(a4, b4, 4));
    chk("w4_borrow", int'(br4), m_borrow(a4, b4, 4));
    chk("w4_diff_q", int'(dq4), e4_dq);
    chk("w4_borrow_q", int'(bq4), e4_bq);
    chk("w4_out_valid", int'(v4), e4_v);
    chk("w4_cnt", int'(c4), e4_c);
    chk("sat_diff", int'(ds), m_diff({3'b0, a_s}, {3'b0, b_s}, 1));
    chk("sat_borrow", int'(brs), m_borrow({3'b0, a_s}, {3'b0, b_s}, 1));
    chk("sat_diff_q", int'(dqs), es_dq);
    chk("sat_borrow_q", int'(bqs), es_bq);
    chk("sat_out_valid", int'(vs), es_v);
    chk("sat_cnt", int'(cs), es_c);
  end

  task automatic step();
    @(posedge clk);
    #10;
  endtask

  logic [1:0] sweep [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
  int exp_d [4] = '{0, 1, 1, 0};
  int exp_b [4] = '{0, 1, 0, 0};

  initial begin
    // Reset state, and the combinational path stays live during reset.
    a1 = 1'b0; b1 = 1'b1;
    #20;
    chk("rst_diff_q", int'(dq1), 0);
    chk("rst_out_valid", int'(v1), 0);
    chk("rst_cnt", int'(c1), 0);
    chk("rst_comb_diff", int'(d1), 1);
    chk("rst_comb_borrow", int'(br1), 1);
    step();
    rst_n = 1'b1;

    // Sweep on the 1-lane instance; 4-lane sees all-borrow for 3 cycles.
    in_valid = 1'b1;
    a_s = 1'b0; b_s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = sweep[i];
      if (i < 3) begin a4 = 4'h0; b4 = 4'hF; end
      else begin a4 = 4'hF; b4 = 4'hF; end
      #1;
      chk("sweep_diff", int'(d1), exp_d[i]);
      chk("sweep_borrow", int'(br1), exp_b[i]);
      step();
      chk("sweep_diff_q", int'(dq1), exp_d[i]);
      chk("sweep_borrow_q", int'(bq1), exp_b[i]);
      if (i == 0) begin
        chk("w4_comb_diff", int'(d4), 15);
        chk("w4_comb_borrow", int'(br4), 15);
      end
    end
    chk("sweep_cnt", int'(c1), 1);
    chk("w4_cnt_12", int'(c4), 12);
    chk("sat_cnt_4", int'(cs), 4);

    // Six more borrowing cycles: the 3-bit counter reaches 10 events, saturated at 7.
    a1 = 1'b0; b1 = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("sat_cnt_7", int'(cs), 7);
    chk("w1_cnt_7", int'(c1), 7);
    step();
    chk("sat_cnt_hold7", int'(cs), 7);
    chk("w1_cnt_8", int'(c1), 8);

    // in_valid low: registered outputs hold while inputs move.
    in_valid = 1'b0;
    a1 = 1'b1; b1 = 1'b0;
    step();
    a1 = 1'b1; b1 = 1'b1;
    step();
    chk("hold_diff_q", int'(dq1), 1);
    chk("hold_borrow_q", int'(bq1), 1);
    chk("hold_out_valid", int'(v1), 0);
    chk("hold_cnt", int'(c1), 8);

    // Clear beats a same-cycle borrow.
    in_valid = 1'b1; cnt_clr = 1'b1;
    a1 = 1'b0; b1 = 1'b1;
    step();
    chk("clr_cnt", int'(c1), 0);
    chk("clr_out_valid", int'(v1), 1);
    cnt_clr = 1'b0;
    step();
    chk("post_clr_cnt", int'(c1), 1);

    // Asynchronous reset between edges.
    a1 = 1'b1; b1 = 1'b0;
    #15;
    rst_n = 1'b0;
    #1;
    chk("arst_diff_q", int'(dq1), 0);
    chk("arst_borrow_q", int'(bq1), 0);
    chk("arst_out_valid", int'(v1), 0);
    chk("arst_cnt", int'(c1), 0);
    chk("arst_w4_cnt", int'(c4), 0);
    chk("arst_sat_cnt", int'(cs), 0);
    a1 = 1'b0; b1 = 1'b1;
    #1;
    chk("arst_comb_diff", int'(d1), 1);
    chk("arst_comb_borrow", int'(br1), 1);
    step();
    chk("arst_held_valid", int'(v1), 0);
    rst_n = 1'b1;
    step();
    chk("release_diff_q", int'(dq1), 1);
    chk("release_cnt", int'(c1), 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
